// File: rtl/stream_byte_serialiser.sv
`default_nettype none
// ============================================================================
//  Module   : stream_byte_serialiser
//  Purpose  : Buffers the 16-bit sample stream in a FIFO and frames it into
//             bytes for the UART transmit path. Each sample is sent MSB first,
//             then LSB. A sync header byte precedes the first sample of every
//             frame of FRAME_LEN samples. Upstream has no backpressure, so
//             samples arriving while the FIFO is full are dropped. Drops are
//             counted and flagged for the register file.
//
//  Ports    :
//    ipClk           in   1    system clock
//    ipReset         in   1    asynchronous, active-high reset
//    ipEnable        in   1    serialisation enable
//    ipStream        in   16   sample from the stream stage
//    ipValid         in   1    single-cycle qualifier for ipStream
//    ipClearOverflow in   1    pulse; clears opOverflow / opDropCount
//    opTxData        out  8    byte to transmitter
//    opTxValid       out  1    opTxData valid
//    ipTxReady       in   1    transmitter accepts byte this cycle
//    opFIFO_Level    out  LW   samples currently stored, 0..DEPTH
//    opOverflow      out  1    sticky drop flag
//    opDropCount     out  16   saturating dropped-sample count
//
//  Revision : 1.0  initial release
// ============================================================================
module stream_byte_serialiser #(
    parameter int           DEPTH     = 16,
    parameter int           FRAME_LEN = 8,
    parameter logic [7:0]   HEADER    = 8'h55,
    parameter int           LW        = $clog2(DEPTH) + 1
) (
    input  logic            ipClk,
    input  logic            ipReset,
    input  logic            ipEnable,
    input  logic [15:0]     ipStream,
    input  logic            ipValid,
    input  logic            ipClearOverflow,
    output logic [7:0]      opTxData,
    output logic            opTxValid,
    input  logic            ipTxReady,
    output logic [LW-1:0]   opFIFO_Level,
    output logic            opOverflow,
    output logic [15:0]     opDropCount
);

    // Address width of the storage array. The pointers carry one extra
    // wrap bit so that full and empty can be told apart.
    localparam int AW  = LW - 1;
    // Frame counter width. FRAME_LEN of 1 still needs a one-bit counter.
    localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [FCW-1:0] c_FC_LAST = FCW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_MSB  = 2'd2,
        S_LSB  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [15:0]    r_mem [DEPTH];
    logic [LW-1:0]  r_wr_ptr;
    logic [LW-1:0]  r_rd_ptr;

    logic [LW-1:0]  w_level;
    logic           w_empty;
    logic           w_full;
    logic           w_push;
    logic           w_drop;
    logic           w_pop;
    logic           w_xfer;
    logic [15:0]    w_head;

    // ------------------------------------------------------------------------
    // Framing state
    // ------------------------------------------------------------------------
    state_t         r_state;
    logic [15:0]    r_hold;
    logic [FCW-1:0] r_frame_cnt;
    logic [FCW-1:0] w_fc_next;

    // Pointer difference is the occupancy. The extra wrap bit keeps the
    // subtraction correct across the modulo-DEPTH address wrap.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Full: same address, opposite wrap bit.
    assign w_full  = (r_wr_ptr[LW-1] != r_rd_ptr[LW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Fullness comes from registered state only. A pop in the same cycle
    // does not make room for an incoming sample, so that sample is dropped.
    assign w_push  = ipValid & ~w_full;
    assign w_drop  = ipValid &  w_full;

    assign w_xfer  = opTxValid & ipTxReady;

    // Pop from IDLE, or back-to-back on the LSB transfer so that sustained
    // traffic has no idle bubble between samples.
    assign w_pop   = ipEnable & ~w_empty &
                     ((r_state == S_IDLE) | ((r_state == S_LSB) & w_xfer));

    assign w_fc_next = (r_frame_cnt == c_FC_LAST) ? '0 : r_frame_cnt + FCW'(1);

    assign opFIFO_Level = w_level;

    // Storage array has no reset. Its contents are only reachable through
    // the pointers, and reset forces the pointers to empty.
    always_ff @(posedge ipClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= ipStream;
        end
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Overflow flag and saturating drop counter. A clear and a drop in the
    // same cycle leave exactly one drop recorded.
    // ------------------------------------------------------------------------
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            opOverflow  <= 1'b0;
            opDropCount <= '0;
        end else if (ipClearOverflow) begin
            opOverflow  <= w_drop;
            opDropCount <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop) begin
            opOverflow <= 1'b1;
            if (opDropCount != 16'hFFFF) begin
                opDropCount <= opDropCount + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Byte framing FSM. The outputs are registered and loaded on the edge
    // that enters each state. While the transmitter stalls, the state does
    // not advance, so data and valid hold stable.
    // ------------------------------------------------------------------------
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_frame_cnt <= '0;
            opTxData    <= '0;
            opTxValid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold    <= w_head;
                        opTxValid <= 1'b1;
                        if (r_frame_cnt == '0) begin
                            r_state  <= S_HDR;
                            opTxData <= HEADER;
                        end else begin
                            r_state  <= S_MSB;
                            opTxData <= w_head[15:8];
                        end
                    end
                end

                S_HDR: begin
                    if (ipTxReady) begin
                        r_state  <= S_MSB;
                        opTxData <= r_hold[15:8];
                    end
                end

                S_MSB: begin
                    if (ipTxReady) begin
                        r_state  <= S_LSB;
                        opTxData <= r_hold[7:0];
                    end
                end

                S_LSB: begin
                    if (ipTxReady) begin
                        r_frame_cnt <= w_fc_next;
                        if (w_pop) begin
                            // Chain straight into the next sample. The header
                            // decision uses the counter value after this
                            // sample completes.
                            r_hold <= w_head;
                            if (w_fc_next == '0) begin
                                r_state  <= S_HDR;
                                opTxData <= HEADER;
                            end else begin
                                r_state  <= S_MSB;
                                opTxData <= w_head[15:8];
                            end
                        end else begin
                            r_state   <= S_IDLE;
                            opTxValid <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    opTxValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_byte_serialiser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_byte_serialiser
//  Purpose  : Self-checking bench for stream_byte_serialiser. The byte stream
//             is modelled as queues: a FIFO of samples, plus the bytes of the
//             sample currently on the transmit port. DUT outputs are compared
//             against this model on every falling edge. Directed scenarios
//             also pin the model with hand-computed byte sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_byte_serialiser;

    localparam int         DEPTH     = 16;
    localparam int         FRAME_LEN = 8;
    localparam logic [7:0] HDR       = 8'h55;
    localparam int         LW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          vld = 1'b0;
    logic          clr = 1'b0;
    logic          rdy = 1'b0;
    logic [15:0]   strm = 16'h0000;

    logic [7:0]    tx_data;
    logic          tx_valid;
    logic [LW-1:0] level;
    logic          ov;
    logic [15:0]   dcnt;

    stream_byte_serialiser #(
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .HEADER    (HDR)
    ) dut (
        .ipClk           (clk),
        .ipReset         (rst),
        .ipEnable        (en),
        .ipStream        (strm),
        .ipValid         (vld),
        .ipClearOverflow (clr),
        .opTxData        (tx_data),
        .opTxValid       (tx_valid),
        .ipTxReady       (rdy),
        .opFIFO_Level    (level),
        .opOverflow      (ov),
        .opDropCount     (dcnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [7:0]  m_cur[$];     // bytes of the sample on the port, head = presented
    logic [15:0] m_fifo[$];    // buffered samples
    int          m_fidx = 0;   // samples popped since reset, modulo FRAME_LEN
    logic        m_ov   = 1'b0;
    logic [15:0] m_cnt  = 16'h0000;

    // Observed transfers
    logic [7:0]  log_b[$];
    int          log_c[$];
    logic [7:0]  exp_b[$];
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Advances the model across the coming rising edge, using the inputs
    // that are stable at the falling edge.
    task automatic model_step();
        bit          xfer;
        bit          full;
        bit          empty;
        bit          pop;
        bit          drop;
        logic [15:0] s;
        xfer  = (m_cur.size() > 0) && rdy;
        full  = (m_fifo.size() == DEPTH);
        empty = (m_fifo.size() == 0);
        pop   = en && !empty && (m_cur.size() == 0 || (xfer && m_cur.size() == 1));
        drop  = vld && full;
        if (xfer) void'(m_cur.pop_front());
        if (pop) begin
            s = m_fifo.pop_front();
            if (m_fidx == 0) m_cur.push_back(HDR);
            m_cur.push_back(s[15:8]);
            m_cur.push_back(s[7:0]);
            m_fidx = (m_fidx + 1) % FRAME_LEN;
        end
        if (vld && !full) m_fifo.push_back(strm);
        if (clr) begin
            m_ov  = drop;
            m_cnt = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            m_ov = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    // Compare process
    always @(negedge clk) begin
        if (rst) begin
            m_cur.delete();
            m_fifo.delete();
            m_fidx = 0;
            m_ov   = 1'b0;
            m_cnt  = 16'h0000;
        end else begin
            cyc++;
            check("txvalid", 32'(tx_valid), 32'(m_cur.size() > 0));
            if (m_cur.size() > 0) check("txdata", 32'(tx_data), 32'(m_cur[0]));
            check("level", 32'(level), 32'(m_fifo.size()));
            check("overflow", 32'(ov), 32'(m_ov));
            check("dropcount", 32'(dcnt), 32'(m_cnt));
            if (tx_valid && rdy) begin
                log_b.push_back(tx_data);
                log_c.push_back(cyc);
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vld = 1'b0;
        clr = 1'b0;
        rdy = 1'b0;
        en  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        log_b.delete();
        log_c.delete();
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(log_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < log_b.size(); i++)
            check(name, 32'(log_b[i]), 32'(exp_b[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;

        // ---------------- Reset state ----------------
        #2 rst = 1'b1;
        tick();
        check("rst_txvalid", 32'(tx_valid), 32'd0);
        check("rst_txdata",  32'(tx_data),  32'd0);
        check("rst_level",   32'(level),    32'd0);
        check("rst_ov",      32'(ov),       32'd0);
        check("rst_dcnt",    32'(dcnt),     32'd0);
        rst = 1'b0;

        // ---------------- Single sample, latency ----------------
        en = 1'b1; rdy = 1'b1;
        clear_log();
        tick();
        vld = 1'b1; strm = 16'hA1B2;
        tick();                               // edge N samples the push
        vld = 1'b0;
        check("t1_level_n",   32'(level),    32'd1);
        check("t1_valid_n",   32'(tx_valid), 32'd0);
        tick();                               // edge N+1 pops
        check("t1_valid_n1",  32'(tx_valid), 32'd1);
        check("t1_hdr",       32'(tx_data),  32'h55);
        check("t1_level_n1",  32'(level),    32'd0);
        tick();
        check("t1_msb",       32'(tx_data),  32'hA1);
        tick();
        check("t1_lsb",       32'(tx_data),  32'hB2);
        tick();
        check("t1_idle",      32'(tx_valid), 32'd0);
        exp_b = '{8'h55, 8'hA1, 8'hB2};
        check_log("t1_bytes");
        if (log_c.size() == 3) check("t1_consec", 32'(log_c[2] - log_c[0]), 32'd2);

        // ---------------- Frame wrap ----------------
        do_reset();
        clear_log();
        en = 1'b1; rdy = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            vld = 1'b1; strm = 16'(i);
            tick();
        end
        vld = 1'b0;
        repeat (25) tick();
        exp_b.delete();
        for (int i = 1; i <= 9; i++) begin
            v = 16'(i);
            if ((i - 1) % FRAME_LEN == 0) exp_b.push_back(HDR);
            exp_b.push_back(v[15:8]);
            exp_b.push_back(v[7:0]);
        end
        check_log("t2_bytes");
        if (log_b.size() == 20) begin
            check("t2_hdr2",  32'(log_b[17]), 32'h55);
            check("t2_last",  32'(log_b[19]), 32'h09);
            check("t2_nogap", 32'(log_c[19] - log_c[0]), 32'd19);
        end
        check("t2_level", 32'(level), 32'd0);

        // ---------------- Backpressure during MSB ----------------
        do_reset();
        clear_log();
        en = 1'b1; rdy = 1'b1;
        vld = 1'b1; strm = 16'hC3D4;
        tick();
        vld = 1'b0;
        tick();                               // header presented, accepted next edge
        tick();                               // MSB presented
        rdy = 1'b0;
        tick();
        check("t3_hold1_v", 32'(tx_valid), 32'd1);
        check("t3_hold1_d", 32'(tx_data),  32'hC3);
        tick();
        check("t3_hold2_d", 32'(tx_data),  32'hC3);
        rdy = 1'b1;
        tick();
        check("t3_lsb",     32'(tx_data),  32'hD4);
        tick();
        check("t3_idle",    32'(tx_valid), 32'd0);
        exp_b = '{8'h55, 8'hC3, 8'hD4};
        check_log("t3_bytes");

        // ---------------- Overflow and clear ----------------
        do_reset();
        clear_log();
        en = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vld = 1'b1; strm = 16'h0100 + 16'(i);
            tick();
        end
        check("t4_level", 32'(level), 32'd16);
        check("t4_ov",    32'(ov),    32'd1);
        check("t4_dcnt",  32'(dcnt),  32'd4);
        clr = 1'b1;                           // vld still high: drop with clear
        tick();
        vld = 1'b0; clr = 1'b0;
        check("t4_clrdrop_dcnt", 32'(dcnt), 32'd1);
        check("t4_clrdrop_ov",   32'(ov),   32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_clr_dcnt", 32'(dcnt), 32'd0);
        check("t4_clr_ov",   32'(ov),   32'd0);
        en = 1'b1; rdy = 1'b1;
        repeat (40) tick();
        check("t4_drained", 32'(level), 32'd0);
        check("t4_nbytes",  32'(log_b.size()), 32'd34);
        if (log_b.size() == 34) begin
            check("t4_b0",  32'(log_b[0]),  32'h55);
            check("t4_b1",  32'(log_b[1]),  32'h01);
            check("t4_b2",  32'(log_b[2]),  32'h00);
            check("t4_b17", 32'(log_b[17]), 32'h55);
            check("t4_b33", 32'(log_b[33]), 32'h0F);
        end

        // ---------------- Enable gating ----------------
        do_reset();
        clear_log();
        en = 1'b0; rdy = 1'b1;
        vld = 1'b1; strm = 16'h1111; tick();
        strm = 16'h2222; tick();
        strm = 16'h3333; tick();
        vld = 1'b0;
        repeat (3) tick();
        check("t5_off_valid", 32'(tx_valid), 32'd0);
        check("t5_off_level", 32'(level),    32'd3);
        en = 1'b1;
        tick();
        check("t5_hdr",   32'(tx_data), 32'h55);
        check("t5_lvl2",  32'(level),   32'd2);
        tick();
        tick();
        tick();                               // sample 2 MSB presented
        check("t5_s2msb", 32'(tx_data), 32'h22);
        check("t5_lvl1",  32'(level),   32'd1);
        en = 1'b0;
        repeat (5) tick();
        check("t5_park_valid", 32'(tx_valid), 32'd0);
        check("t5_park_level", 32'(level),    32'd1);
        exp_b = '{8'h55, 8'h11, 8'h11, 8'h22, 8'h22};
        check_log("t5_bytes");

        // ---------------- Async reset mid-LSB ----------------
        do_reset();
        clear_log();
        en = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld = 1'b1; strm = 16'hA5C0 + 16'(i);
            tick();
        end
        vld = 1'b0;
        en = 1'b1; rdy = 1'b1;
        tick();                               // pop: header presented
        tick();                               // MSB presented
        tick();                               // LSB presented
        rdy = 1'b0;
        check("t6_lsb",   32'(tx_data), 32'hC0);
        check("t6_lvl5",  32'(level),   32'd5);
        #2 rst = 1'b1;                        // mid-cycle, no clock edge
        #1;
        check("t6_async_valid", 32'(tx_valid), 32'd0);
        check("t6_async_level", 32'(level),    32'd0);
        tick();
        rst = 1'b0;
        clear_log();
        en = 1'b1; rdy = 1'b1;
        vld = 1'b1; strm = 16'hBEEF;
        tick();
        vld = 1'b0;
        repeat (6) tick();
        exp_b = '{8'h55, 8'hBE, 8'hEF};
        check_log("t6_bytes");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
